pipe_buffer_fifo: RTL and testbench

PIPE_BUFFER_FIFO -- requirements
Module: pipe_buffer_fifo

---
 rtl/pipe_buffer_fifo.sv | 65 ++++++
 tb/tb_pipe_buffer_fifo.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pipe_buffer_fifo.sv
// rtl/pipe_buffer_fifo.sv - first-word-fall-through FIFO with flush, almost-full and sticky overflow flag
module pipe_buffer_fifo #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4,
   parameter int AF_LEVEL   = DEPTH - 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   output logic                         rd_valid,
   input  logic                         rd_ready,
   output logic [DATA_WIDTH-1:0]        rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         almost_full,
   output logic                         ovf_err
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]     wr_ptr;
   logic [ADDR_W-1:0]     rd_ptr;
   logic                  push;
   logic                  pop;

   // No full-bypass: a full FIFO refuses writes even when a pop happens that cycle
   assign wr_ready    = (count != FULL_CNT) & ~rst;
   assign rd_valid    = (count != '0);
   assign rd_data     = rd_valid ? mem[rd_ptr] : '0;
   assign almost_full = (count >= AF_CNT);
   assign push        = wr_valid & wr_ready & ~flush;
   assign pop         = rd_valid & rd_ready & ~flush;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
         if (push & ~pop)      count <= count + CNT_W'(1);
         else if (pop & ~push) count <= count - CNT_W'(1);
      end
   end

   // Sticky until reset; flush deliberately leaves it alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                          ovf_err <= 1'b0;
      else if (wr_valid & (count == FULL_CNT) & ~flush) ovf_err <= 1'b1;
   end
endmodule

// File: tb/tb_pipe_buffer_fifo.sv
// tb/tb_pipe_buffer_fifo.sv - randomized queue-model bench over four width/depth configurations
module tb_pipe_buffer_fifo;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        wr_valid = 1'b0;
   logic        rd_ready = 1'b0;
   logic [63:0] wr_data = '0;
   int          n_checks = 0;
   int          n_fails = 0;

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : gen_cfg
      localparam int DW = (g == 1 || g == 3) ? 8 : 64;
      localparam int D  = (g == 0) ? 4 : (g == 1) ? 2 : 16;
      localparam int AF = D - 1;

      logic [DW-1:0]            rdd;
      logic [$clog2(D+1)-1:0]   cnt;
      logic                     wrr, rdv, af, ovf;
      logic [63:0]              q[$];
      bit                       m_ovf = 1'b0;

      pipe_buffer_fifo #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
         .clk(clk), .rst(rst), .flush(flush),
         .wr_valid(wr_valid), .wr_ready(wrr), .wr_data(wr_data[DW-1:0]),
         .rd_valid(rdv), .rd_ready(rd_ready), .rd_data(rdd),
         .count(cnt), .almost_full(af), .ovf_err(ovf)
      );

      // Reference: a bounded queue of words; full/empty judged from its size alone
      always @(posedge clk or posedge rst) begin
         if (rst) begin
            q.delete();
            m_ovf = 1'b0;
         end else if (flush) begin
            q.delete();
         end else begin
            bit do_push, do_pop;
            do_push = wr_valid && (q.size() < D);
            do_pop  = rd_ready && (q.size() > 0);
            if (wr_valid && q.size() == D) m_ovf = 1'b1;
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back({{(64-DW){1'b0}}, wr_data[DW-1:0]});
         end
      end

      always @(negedge clk) begin
         logic [63:0] exp_data;
         exp_data = (q.size() > 0) ? q[0] : 64'd0;
         check_val($sformatf("cfg%0d count", g), 64'(cnt), 64'(q.size()));
         check_val($sformatf("cfg%0d rd_valid", g), 64'(rdv), 64'(q.size() > 0));
         check_val($sformatf("cfg%0d rd_data", g), 64'(rdd), exp_data);
         check_val($sformatf("cfg%0d wr_ready", g), 64'(wrr), 64'((q.size() < D) && !rst));
         check_val($sformatf("cfg%0d almost_full", g), 64'(af), 64'(q.size() >= AF));
         check_val($sformatf("cfg%0d ovf_err", g), 64'(ovf), 64'(m_ovf));
      end
   end

   task automatic cycle(input bit wv, input logic [63:0] wd, input bit rr, input bit fl);
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
      flush    = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // basic push/pop
      cycle(1, 20, 0, 0);
      cycle(1, 22, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      // sustained push+pop across pointer wrap
      cycle(1, 99, 0, 0);
      for (int i = 0; i < 48; i++) cycle(1, 64'(100 + i), 1, 0);
      for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0);

      // flush with a concurrent write
      for (int i = 0; i < 3; i++) cycle(1, 64'(40 + i), 0, 0);
      cycle(1, 50, 0, 1);
      cycle(0, 0, 0, 0);
      cycle(1, 50, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      // fill past full for every depth, then drain
      for (int i = 1; i <= 17; i++) cycle(1, 64'(i), 0, 0);
      for (int i = 0; i < 17; i++) cycle(0, 0, 1, 0);

      // asynchronous reset between edges with two words stored
      cycle(1, 64'h77, 0, 0);
      cycle(1, 64'h78, 0, 0);
      wr_valid = 1'b0;
      #2 rst = 1'b1;
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      cycle(1, 64'h5a5a, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      // random traffic with shifting read pressure
      for (int i = 0; i < 2400; i++) begin
         int rd_pct;
         rd_pct = ((i / 200) % 3 == 0) ? 20 : ((i / 200) % 3 == 1) ? 50 : 85;
         cycle(($urandom_range(99) < 70), {$urandom, $urandom},
               ($urandom_range(99) < rd_pct), ($urandom_range(99) < 2));
      end

      cycle(0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end
endmodule
